// File: rtl/dmem_stall_ctrl.sv
// Data-memory stage: word-organised RAM with a fixed multi-cycle load latency.
// Stall holds the PC and the writeback enable while a load is in flight.
module dmem_stall_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Stall,
    output logic        AddrErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LAT) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic            byte_q, byte_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            stall;
    logic            wr_en;

    logic [31:0]     mem [DEPTH];

    logic            legal;
    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   rd_idx;
    logic [1:0]      rd_lane;
    logic            rd_byte;
    logic [31:0]     rd_word;
    logic [31:0]     rd_val;

    assign req_idx = Addr[AW+1:2];
    assign legal   = (Addr[31:AW+2] == '0) && (ByteOp || (Addr[1:0] == 2'b00));

    // In IDLE the read path sees the live request so that LAT=1 can complete directly.
    assign rd_idx  = (state_q == StIdle) ? req_idx   : idx_q;
    assign rd_lane = (state_q == StIdle) ? Addr[1:0] : lane_q;
    assign rd_byte = (state_q == StIdle) ? ByteOp    : byte_q;
    assign rd_word = mem[rd_idx];
    assign rd_val  = rd_byte ? {24'h0, rd_word[{rd_lane, 3'b000} +: 8]} : rd_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        byte_d  = byte_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemRead) begin
                    stall  = 1'b1;
                    idx_d  = req_idx;
                    lane_d = Addr[1:0];
                    byte_d = ByteOp;
                    if (!legal) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (LAT == 1) begin
                        rdata_d = rd_val;
                        state_d = StDone;
                    end else begin
                        cnt_d   = CW'(LAT - 1);
                        state_d = StBusy;
                    end
                end else if (MemWrite) begin
                    if (legal) begin
                        wr_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                // Finishing on the last count value keeps Stall high for exactly LAT cycles.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    rdata_d = rd_val;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            byte_q  <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            byte_q  <= byte_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            if (ByteOp) begin
                mem[req_idx][{Addr[1:0], 3'b000} +: 8] <= WriteData[7:0];
            end else begin
                mem[req_idx] <= WriteData;
            end
        end
    end

    assign ReadData  = rdata_q;
    assign ReadValid = (state_q == StDone);
    assign Stall     = stall;
    assign AddrErr   = err_q;

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
Data-memory stage directly downstream of the single-cycle datapath. It consumes the ALU-computed address, the store data and the memory-control strobes, and returns load data on ReadData. It holds a word-organised RAM with a fixed multi-cycle read latency and supports word and byte accesses. While a load is in flight it raises Stall, which the control/PC logic uses to freeze fetch and register writeback.

Parameters:
DEPTH, 64, number of 32-bit words; must be a power of 2, minimum 4.
LAT, 2, load latency in clock edges after the request cycle; must be at least 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
MemRead  input  1  load request; held stable by the requester while Stall=1.
MemWrite  input  1  store request.
ByteOp  input  1  1 = byte access (LDRB/STRB), 0 = word access.
Addr  input  32  byte address (ALUResult).
WriteData  input  32  store data; for a byte store, bits [7:0] are used.
ReadData  output  32  load result; valid only when ReadValid=1.
ReadValid  output  1  one-cycle pulse: the load completes this cycle.
Stall  output  1  1 = hold the PC and suppress the writeback enable this cycle.
AddrErr  output  1  one-cycle pulse flagging a rejected access.

Behaviour:
- Reset: reset=0 forces state IDLE and clears ReadData, ReadValid, AddrErr and the latency counter; Stall reads 0. RAM contents are not cleared. Reset during a load aborts it with no side effects.
- Word index = Addr[log2(DEPTH)+1:2]; byte lane = Addr[1:0], little-endian (lane 0 = bits [7:0]).
- An access is illegal if Addr >= 4*DEPTH, or if it is a word access with Addr[1:0] != 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, MemRead=1:
  - Capture the index, lane and ByteOp.
  - Stall=1 combinationally in this cycle.
  - Legal access: load the counter with LAT-1 and go to BUSY.
  - Illegal access: go straight to DONE with ReadData=0 and AddrErr=1.
  - MemWrite is ignored when MemRead is also 1 (the load has priority).
- BUSY: Stall=1. Decrement the counter each edge. At counter=0, register the RAM data into ReadData and go to DONE. For a byte load, ReadData = zero-extended selected lane.
- DONE: ReadValid=1, Stall=0. All inputs are ignored, because they still carry the same load, so nothing retriggers. The next edge returns to IDLE and clears ReadValid and AddrErr.
- Load timing: the request cycle plus LAT-1 BUSY cycles keep Stall=1 for exactly LAT cycles; DONE follows, giving LAT+1 cycles per load.
- IDLE, MemWrite=1, MemRead=0:
  - Single cycle, Stall=0.
  - Legal word store: the RAM word is written at the edge.
  - Legal byte store: only the addressed lane is written.
  - Illegal store: no write; AddrErr=1 in the following cycle only.
- IDLE with neither request: no change; ReadValid=0.
- Store data is visible to any later load (no write buffering).
- The counter is ceil(log2(LAT))+1 bits wide; it must not wrap while in BUSY.

Test Plan:
- Reset release: reset=0 then 1 -> Stall=0, ReadValid=0, AddrErr=0, ReadData=0, state IDLE.
- Word store then load, LAT=2: store 0xDEADBEEF to 0x10; load 0x10 -> Stall=1 for 2 cycles, then ReadValid=1 with ReadData=0xDEADBEEF, then IDLE.
- Byte ops: word 0x11223344 at 0x20; STRB 0xAA to 0x22 -> word reads 0x11AA3344; LDRB 0x23 -> ReadData=0x00000011.
- Illegal accesses:
  - Word load at 0x21 -> next cycle ReadValid=1, AddrErr=1, ReadData=0.
  - Store to 4*DEPTH -> no RAM change; AddrErr pulses 1 cycle.
- MemRead=MemWrite=1 at 0x10 holding 0x5 with WriteData=0x9 -> ReadData=0x5; RAM still holds 0x5.
- Reset asserted in BUSY -> Stall drops immediately and ReadValid never pulses; a fresh load afterwards behaves normally. Repeat the latency check with LAT=1 (Stall 1 cycle) and LAT=4 (Stall 4 cycles).
